// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the packet-bus round-robin controller.
package bus_ctrl_pkg;

  localparam int DEST_W     = 8;
  localparam int DROP_CNT_W = 16;
  localparam int MAX_PKT_W  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ROUTE = 2'd2
  } state_e;

  // Destination ID lives in the top DEST_W bits of a pkt_w-wide packet (pkt_w <= MAX_PKT_W).
  function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt, input int pkt_w);
    return DEST_W'(pkt >> (pkt_w - DEST_W));
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_grant_picker #(
  parameter int drvrs = 4,
  parameter int IDX_W = 2
) (
  input  logic [drvrs-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam logic [drvrs-1:0] LSB_ONE = {{(drvrs-1){1'b0}}, 1'b1};

  logic [drvrs-1:0] rot_s;
  logic [drvrs-1:0] pick_s;
  logic [IDX_W-1:0] off_s;
  int               sum_s;

  // Rotate so bit 0 is ptr+1, isolate the lowest set bit, then rotate the index back.
  always_comb begin
    rot_s  = drvrs'({req, req} >> (int'(ptr) + 1));
    pick_s = rot_s & (~rot_s + LSB_ONE);
    off_s  = '0;
    for (int i = 0; i < drvrs; i++) begin
      off_s = off_s | (pick_s[i] ? IDX_W'(i) : '0);
    end
    sum_s   = int'(ptr) + 1 + int'(off_s);
    gnt_idx = (sum_s >= drvrs) ? IDX_W'(sum_s - drvrs) : IDX_W'(sum_s);
    gnt_vld = |req;
  end

endmodule

// File: rtl/bus_rr_controller.sv
// Round-robin packet-bus scheduler: grant, pop, decode dest ID, push or broadcast.
// Optional BUS_DROP_CNT_EN enables the saturating invalid-destination counter.
module bus_rr_controller
  import bus_ctrl_pkg::*;
#(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [3:0]               grant_id,
  output logic [15:0]              drop_cnt
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] LSB_ONE = {{(drvrs-1){1'b0}}, 1'b1};

  state_e             state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_vld_s;
  logic [drvrs-1:0]   pop_r;
  logic [drvrs-1:0]   push_r;
  logic [drvrs-1:0]   route_s;
  logic [pckg_sz-1:0] pkt_r;
  logic [pckg_sz-1:0] head_s;
  logic [DEST_W-1:0]  head_dest_s;
  logic               busy_r;

  rr_grant_picker #(.drvrs(drvrs), .IDX_W(IDX_W)) u_picker (
    .req     (pndng),
    .ptr     (ptr_r),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

  // Destination mask of the granted FIFO's head, registered into push as it is captured.
  always_comb begin
    head_s      = D_pop[int'(grant_r)*pckg_sz +: pckg_sz];
    head_dest_s = dest_of(MAX_PKT_W'(head_s), pckg_sz);
    route_s     = '0;
    if (head_dest_s == broadcast) begin
      route_s = ~(LSB_ONE << grant_r);
    end else if (int'(head_dest_s) < drvrs) begin
      route_s = LSB_ONE << head_dest_s;
    end else begin
      route_s = '0;
    end
  end

  // Arbitration FSM: IDLE picks a winner, GRANT pops and captures, ROUTE presents the packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= IDX_W'(drvrs - 1);
      grant_r <= '0;
      pop_r   <= '0;
      push_r  <= '0;
      pkt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          push_r <= '0;
          if (gnt_vld_s) begin
            grant_r <= gnt_idx_s;
            ptr_r   <= gnt_idx_s;
            pop_r   <= LSB_ONE << gnt_idx_s;
            busy_r  <= 1'b1;
            state_r <= GRANT;
          end else begin
            pop_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        GRANT: begin
          pop_r   <= '0;
          pkt_r   <= head_s;
          push_r  <= route_s;
          state_r <= ROUTE;
        end
        ROUTE: begin
          push_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          pop_r   <= '0;
          push_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign pop      = pop_r;
  assign push     = push_r;
  assign D_push   = pkt_r;
  assign busy     = busy_r;
  assign grant_id = 4'(grant_r);

`ifdef BUS_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic [DEST_W-1:0]     pkt_dest_s;
  logic                  drop_s;

  // A packet addressed neither to a driver nor to broadcast is dropped.
  always_comb begin
    pkt_dest_s = dest_of(MAX_PKT_W'(pkt_r), pckg_sz);
    drop_s     = (pkt_dest_s != broadcast) && (int'(pkt_dest_s) >= drvrs);
  end

  // Saturating drop counter, bumped as the dropped packet leaves ROUTE.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= '0;
    end else if ((state_r == ROUTE) && drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_bus_rr_controller.sv
// Scoreboard bench for bus_rr_controller: FIFO models feed the DUT, a queue-based
// round-robin model predicts pops and pushes, and a negedge monitor checks them.
module tb_bus_rr_controller;

  typedef struct {
    int idx;
    int drops;
  } pop_ent_t;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] data;
  } push_ent_t;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] D_push;
  logic        busy;
  logic [3:0]  grant_id;
  logic [15:0] drop_cnt;

  logic [15:0] fifo_q [4][$];
  logic [15:0] mq     [4][$];
  pop_ent_t    exp_pop_q[$];
  push_ent_t   exp_push_q[$];
  pop_ent_t    pe;
  push_ent_t   ue;
  int          m_last;
  int          m_drops;
  int          checks;
  int          errors;
  int          cyc;
  int          last_pop_cyc;

  bus_rr_controller #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_drop(input int d);
`ifdef BUS_DROP_CNT_EN
    return d;
`else
    return 0;
`endif
  endfunction

  function automatic bit fifos_pending();
    return (fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size() + fifo_q[3].size()) != 0;
  endfunction

  task automatic drive_fifo();
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (fifo_q[i].size() != 0);
      D_pop[i*16 +: 16] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : 16'h0;
    end
  endtask

  task automatic add_pkt(input int i, input logic [15:0] d);
    fifo_q[i].push_back(d);
    mq[i].push_back(d);
  endtask

  // Reference: every packet of the batch is waiting, so each grant goes to the first
  // non-empty driver after the previous winner; destinations decoded from the top byte.
  task automatic start_batch();
    int          w;
    int          c;
    logic [15:0] pkt;
    logic [7:0]  dst;
    logic [3:0]  m;
    drive_fifo();
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (w < 0 && mq[c].size() != 0) w = c;
      end
      pkt    = mq[w].pop_front();
      m_last = w;
      exp_pop_q.push_back('{idx: w, drops: m_drops});
      dst = pkt[15:8];
      if (dst == 8'hFF) begin
        m = 4'b1111;
        m[w] = 1'b0;
        exp_push_q.push_back('{mask: m, data: pkt});
      end else if (dst < 8'd4) begin
        m = 4'b0000;
        m[dst[1:0]] = 1'b1;
        exp_push_q.push_back('{mask: m, data: pkt});
      end else begin
        m_drops++;
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] p;
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) void'(fifo_q[i].pop_front());
    end
    drive_fifo();
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || fifos_pending() || exp_pop_q.size() != 0 || exp_push_q.size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n >= 300), 32'd0);
    cycle();
  endtask

  // Monitor: pop and push events are checked against the scoreboard queues.
  always @(negedge clk) begin
    logic [3:0] oh;
    cyc++;
    if (!reset) begin
      if (pop != 4'b0) begin
        chk("pop_push_overlap", 32'(push), 32'd0);
        chk("busy_on_pop", 32'(busy), 32'd1);
        if (exp_pop_q.size() == 0) begin
          chk("unexpected_pop", 32'(pop), 32'd0);
        end else begin
          pe = exp_pop_q.pop_front();
          oh = 4'b0001 << pe.idx;
          chk("pop_onehot", 32'(pop), 32'(oh));
          chk("grant_id", 32'(grant_id), 32'(pe.idx));
          chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop(pe.drops)));
          last_pop_cyc = cyc;
        end
      end
      if (push != 4'b0) begin
        chk("busy_on_push", 32'(busy), 32'd1);
        if (exp_push_q.size() == 0) begin
          chk("unexpected_push", 32'(push), 32'd0);
        end else begin
          ue = exp_push_q.pop_front();
          chk("push_mask", 32'(push), 32'(ue.mask));
          chk("D_push", 32'(D_push), 32'(ue.data));
          chk("push_latency", 32'(cyc - last_pop_cyc), 32'd1);
        end
      end
    end
  end

  initial begin
    logic [7:0] dst;
    int         n;
    checks = 0; errors = 0; cyc = 0; last_pop_cyc = 0;
    m_last = 3; m_drops = 0;
    reset = 1'b1; pndng = 4'b0; D_pop = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_D_push", 32'(D_push), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;

    add_pkt(1, 16'h0305); start_batch(); drain();
    add_pkt(0, 16'hFFAA); start_batch(); drain();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) add_pkt(i, {8'h00, 8'(r * 16 + i)});
    end
    start_batch(); drain();
    add_pkt(2, 16'h0711); start_batch(); drain();
    chk("drop_cnt_invalid", 32'(drop_cnt), 32'(exp_drop(m_drops)));

    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 4; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          case ($urandom_range(0, 5))
            0, 1, 2, 3: dst = 8'($urandom_range(0, 3));
            4:          dst = 8'hFF;
            default:    dst = 8'($urandom_range(4, 254));
          endcase
          add_pkt(i, {dst, 8'($urandom)});
        end
      end
      start_batch(); drain();
    end

    // Reset while a packet sits in ROUTE; pointer must restart at driver 0.
    add_pkt(2, 16'h0011); start_batch();
    n = 0;
    while (pop == 4'b0 && n < 20) begin
      cycle();
      n++;
    end
    chk("reset_test_pop_timeout", 32'(n >= 20), 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("midrst_push", 32'(push), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pop", 32'(pop), 32'd0);
    reset = 1'b0;
    exp_pop_q.delete(); exp_push_q.delete();
    m_last = 3; m_drops = 0;
    cycle();
    chk("postrst_push", 32'(push), 32'd0);
    add_pkt(3, 16'h0122); add_pkt(0, 16'hFF33); start_batch(); drain();

    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("idle_quiet", {29'd0, pop != 4'b0, push != 4'b0, busy}, 32'd0);
    end
    chk("final_drop_cnt", 32'(drop_cnt), 32'(exp_drop(m_drops)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
